debug_dump_sequencer: RTL

DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

---
 rtl/debug_dump_sequencer_pkg.sv | 26 ++
 rtl/debug_dump_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/debug_dump_sequencer_pkg.sv
// Shared constants for the debug dump sequencer: FSM encodings and the fixed
// word ordering of a dump (PC, cycle count, register bank, data memory).
package debug_dump_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SELECT  = 3'd1;
  localparam state_t ST_LATCH   = 3'd2;
  localparam state_t ST_SEND    = 3'd3;
  localparam state_t ST_WAIT    = 3'd4;
  localparam state_t ST_ADVANCE = 3'd5;
  localparam state_t ST_FINISH  = 3'd6;

  localparam int unsigned WORD_PC          = 0;
  localparam int unsigned WORD_CYCLES      = 1;
  localparam int unsigned WORD_REG_BASE    = 2;
  localparam int unsigned DEFAULT_NUM_REGS = 32;
  localparam int unsigned WORD_MEM_BASE    = WORD_REG_BASE + DEFAULT_NUM_REGS;

  // Memory words start right after the register bank, whatever its size.
  function automatic int unsigned word_mem_base(input int unsigned num_regs);
    return WORD_REG_BASE + num_regs;
  endfunction

endpackage

// File: rtl/debug_dump_sequencer.sv
// Streams PC, cycle count, register bank and data memory out over a UART
// byte interface, LSB first, one word at a time.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int unsigned BITS_SIZE     = 32,
  parameter int unsigned SIZE_TRAMA    = 8,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned NUM_MEM_WORDS = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [BITS_SIZE-1:0]         i_mips_pc,
  input  logic [BITS_SIZE-1:0]         i_cycle_count,
  input  logic [BITS_SIZE-1:0]         i_data_register,
  input  logic [BITS_SIZE-1:0]         i_data_mem,
  input  logic                         i_tx_done,
  output logic                         o_tx_start,
  output logic [SIZE_TRAMA-1:0]        o_tx_data,
  output logic [$clog2(BITS_SIZE)-1:0] o_select_addr_registers,
  output logic [BITS_SIZE-1:0]         o_select_addr_memdata,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned TOTAL_WORDS    = 2 + NUM_REGS + NUM_MEM_WORDS;
  localparam int unsigned BYTES_PER_WORD = BITS_SIZE / SIZE_TRAMA;
  localparam int unsigned WORD_W         = $clog2(TOTAL_WORDS + 1);
  localparam int unsigned BYTE_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned REG_AW         = $clog2(BITS_SIZE);

  localparam logic [WORD_W-1:0] PC_W       = WORD_W'(WORD_PC);
  localparam logic [WORD_W-1:0] CYCLES_W   = WORD_W'(WORD_CYCLES);
  localparam logic [WORD_W-1:0] REG_BASE_W = WORD_W'(WORD_REG_BASE);
  localparam logic [WORD_W-1:0] MEM_BASE_W = WORD_W'(word_mem_base(NUM_REGS));
  localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(TOTAL_WORDS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(BYTES_PER_WORD - 1);

  state_t               state_q, state_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [BYTE_W-1:0]    byte_q, byte_d;
  logic [BITS_SIZE-1:0] shift_q, shift_d;

  logic                 is_reg_word, is_mem_word;
  logic [WORD_W-1:0]    reg_offset, mem_offset;
  logic [BITS_SIZE-1:0] src_word;

  assign is_reg_word = (word_q >= REG_BASE_W) && (word_q < MEM_BASE_W);
  assign is_mem_word = (word_q >= MEM_BASE_W);
  assign reg_offset  = word_q - REG_BASE_W;
  assign mem_offset  = word_q - MEM_BASE_W;

  // Sources are read synchronously: address shown in SELECT, data valid in LATCH.
  always_comb begin
    src_word = i_data_mem;
    if (word_q == PC_W) begin
      src_word = i_mips_pc;
    end else if (word_q == CYCLES_W) begin
      src_word = i_cycle_count;
    end else if (is_reg_word) begin
      src_word = i_data_register;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SELECT;
          word_d  = '0;
          byte_d  = '0;
        end
      end
      ST_SELECT: state_d = ST_LATCH;
      ST_LATCH: begin
        shift_d = src_word;
        state_d = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (byte_q != LAST_BYTE) begin
          shift_d = shift_q >> SIZE_TRAMA;
          byte_d  = byte_q + BYTE_W'(1);
          state_d = ST_SEND;
        end else if (word_q != LAST_WORD) begin
          word_d  = word_q + WORD_W'(1);
          byte_d  = '0;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
    end
  end

  // Outputs decode straight from reset-cleared state, so reset zeroes them at once.
  assign o_tx_start = (state_q == ST_SEND);
  assign o_tx_data  = shift_q[SIZE_TRAMA-1:0];
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_FINISH);

  assign o_select_addr_registers =
      (state_q == ST_SELECT && is_reg_word) ? REG_AW'(reg_offset) : '0;
  assign o_select_addr_memdata =
      (state_q == ST_SELECT && is_mem_word) ? BITS_SIZE'(mem_offset) : '0;

endmodule
